// File: rtl/pipemem_pkg.sv
// Shared types and defaults for the pipeline memory-port arbiter.
// Holds the FSM state encoding, the grant encoding and the timeout default.
package pipemem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef enum logic {
      GRANT_FETCH = 1'b0,
      GRANT_DATA  = 1'b1
   } grant_t;

   localparam int MAX_WAIT_DEFAULT = 15;

endpackage

// File: rtl/pipemem_wait_timer.sv
// Wait counter for an outstanding memory access: cleared when an access starts,
// counts each cycle without an acknowledge and flags the cycle it runs out.
module pipemem_wait_timer
   import pipemem_pkg::*;
#(
   parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
   input  logic clock,
   input  logic resetn,
   input  logic clear,
   input  logic inc,
   output logic expire
);

   localparam int CW = $clog2(MAX_WAIT + 1);

   logic [CW-1:0] count;

   always_ff @(posedge clock) begin
      if (!resetn) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc) begin
         count <= count + 1'b1;
      end
   end

   // Fires in the cycle whose missing ack would bring the count to MAX_WAIT.
   assign expire = inc && (count == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/pipemem_arbiter.sv
// Arbitrates the fetch and memory stages onto one shared memory port,
// alternating grants under contention and aborting accesses that never ack.
module pipemem_arbiter
   import pipemem_pkg::*;
#(
   parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,
   output logic        i_done,
   input  logic        d_rd,
   input  logic        d_wr,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_done,
   output logic        stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        err
);

   state_t      state, state_nxt;
   grant_t      last_grant, last_grant_nxt;
   logic        mem_req_nxt, mem_we_nxt;
   logic [31:0] mem_addr_nxt, mem_wdata_nxt;
   logic [31:0] i_rdata_nxt, d_rdata_nxt;
   logic        i_done_nxt, d_done_nxt, err_nxt;
   logic        d_pend, take_data;
   logic        timer_clear, timer_inc, timer_expire;

   assign d_pend    = d_rd | d_wr;
   // Data wins ties unless it had the previous grant.
   assign take_data = d_pend && (!i_req || (last_grant != GRANT_DATA));

   assign timer_clear = (state == ST_IDLE) && (d_pend || i_req);
   assign timer_inc   = (state == ST_ACC) && !mem_ack;

   assign stall = (d_pend & ~d_done) | (i_req & ~i_done);

   pipemem_wait_timer #(
      .MAX_WAIT (MAX_WAIT)
   ) u_wait_timer (
      .clock  (clock),
      .resetn (resetn),
      .clear  (timer_clear),
      .inc    (timer_inc),
      .expire (timer_expire)
   );

   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      mem_req_nxt    = mem_req;
      mem_we_nxt     = mem_we;
      mem_addr_nxt   = mem_addr;
      mem_wdata_nxt  = mem_wdata;
      i_rdata_nxt    = i_rdata;
      d_rdata_nxt    = d_rdata;
      i_done_nxt     = 1'b0;
      d_done_nxt     = 1'b0;
      err_nxt        = err;

      case (state)
         ST_IDLE: begin
            if (take_data) begin
               last_grant_nxt = GRANT_DATA;
               mem_req_nxt    = 1'b1;
               mem_we_nxt     = d_wr;
               mem_addr_nxt   = d_addr;
               mem_wdata_nxt  = d_wdata;
               state_nxt      = ST_ACC;
            end else if (i_req) begin
               last_grant_nxt = GRANT_FETCH;
               mem_req_nxt    = 1'b1;
               mem_we_nxt     = 1'b0;
               mem_addr_nxt   = i_addr;
               mem_wdata_nxt  = '0;
               state_nxt      = ST_ACC;
            end
         end

         ST_ACC: begin
            // An ack in the expiring cycle still completes the access normally.
            if (mem_ack || timer_expire) begin
               mem_req_nxt = 1'b0;
               mem_we_nxt  = 1'b0;
               state_nxt   = ST_DONE;
               if (!mem_ack) begin
                  err_nxt = 1'b1;
               end
               if (last_grant == GRANT_DATA) begin
                  d_done_nxt  = 1'b1;
                  d_rdata_nxt = (mem_ack && !mem_we) ? mem_rdata : '0;
               end else begin
                  i_done_nxt  = 1'b1;
                  i_rdata_nxt = mem_ack ? mem_rdata : '0;
               end
            end
         end

         ST_DONE: begin
            state_nxt = ST_IDLE;
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state      <= ST_IDLE;
         last_grant <= GRANT_FETCH;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         i_rdata    <= '0;
         d_rdata    <= '0;
         i_done     <= 1'b0;
         d_done     <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
         mem_req    <= mem_req_nxt;
         mem_we     <= mem_we_nxt;
         mem_addr   <= mem_addr_nxt;
         mem_wdata  <= mem_wdata_nxt;
         i_rdata    <= i_rdata_nxt;
         d_rdata    <= d_rdata_nxt;
         i_done     <= i_done_nxt;
         d_done     <= d_done_nxt;
         err        <= err_nxt;
      end
   end

endmodule

// File: tb/tb_pipemem_arbiter.sv
// Bench for pipemem_arbiter: directed scenarios plus randomized rounds against a
// transaction-level model of grant order, completion latency and memory contents.
module tb_pipemem_arbiter;

   localparam int          MAX_WAIT = 15;
   localparam logic [31:0] FILL     = 32'hC3C3_3C3C;

   logic        clock;
   logic        resetn;
   logic        i_req;
   logic [31:0] i_addr;
   logic [31:0] i_rdata;
   logic        i_done;
   logic        d_rd;
   logic        d_wr;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_done;
   logic        stall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        err;

   int total;
   int bad;

   // Model state: who is requesting, who was granted last, expected held outputs.
   bit          i_pend;
   bit          d_pend_m;
   bit          last_data;
   bit          err_m;
   logic [31:0] exp_i_rdata;
   logic [31:0] exp_d_rdata;
   logic [31:0] ref_mem [logic [31:0]];

   // Memory environment controls.
   logic [31:0] env_mem [logic [31:0]];
   int          resp_lat;
   bit          resp_never;
   bit          resp_spur;
   int          cycles_in;

   pipemem_arbiter #(
      .MAX_WAIT (MAX_WAIT)
   ) dut (
      .clock     (clock),
      .resetn    (resetn),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_rdata   (i_rdata),
      .i_done    (i_done),
      .d_rd      (d_rd),
      .d_wr      (d_wr),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_rdata   (d_rdata),
      .d_done    (d_done),
      .stall     (stall),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .err       (err)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Memory responder: acks the resp_lat-th cycle after mem_req rises.
   initial begin
      mem_ack   = 1'b0;
      mem_rdata = '0;
      cycles_in = 0;
      forever begin
         @(posedge clock);
         #1;
         mem_ack = 1'b0;
         if (mem_req === 1'b1) begin
            if (!resp_never && cycles_in == resp_lat) begin
               mem_ack   = 1'b1;
               mem_rdata = env_mem.exists(mem_addr) ? env_mem[mem_addr] : (mem_addr ^ FILL);
               if (mem_we === 1'b1) env_mem[mem_addr] = mem_wdata;
            end
            cycles_in++;
         end else begin
            cycles_in = 0;
            if (resp_spur) begin
               mem_ack   = 1'b1;
               mem_rdata = 32'hBAD0_BAD0;
            end
         end
      end
   end

   function automatic logic [31:0] ref_read(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : (a ^ FILL);
   endfunction

   function automatic logic [31:0] rand_addr();
      return 32'h100 + (32'($urandom_range(0, 7)) << 2);
   endfunction

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check_reset(input string tag, input bit exp_stall);
      check_output({tag, "_mem_req"},   32'(mem_req),   0);
      check_output({tag, "_mem_we"},    32'(mem_we),    0);
      check_output({tag, "_mem_addr"},  mem_addr,       0);
      check_output({tag, "_mem_wdata"}, mem_wdata,      0);
      check_output({tag, "_i_done"},    32'(i_done),    0);
      check_output({tag, "_d_done"},    32'(d_done),    0);
      check_output({tag, "_i_rdata"},   i_rdata,        0);
      check_output({tag, "_d_rdata"},   d_rdata,        0);
      check_output({tag, "_err"},       32'(err),       0);
      check_output({tag, "_stall"},     32'(stall),     32'(exp_stall));
   endtask

   task automatic model_reset();
      last_data   = 1'b0;
      err_m       = 1'b0;
      exp_i_rdata = '0;
      exp_d_rdata = '0;
   endtask

   task automatic set_data(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] w);
      d_rd     = rd;
      d_wr     = wr;
      d_addr   = a;
      d_wdata  = w;
      d_pend_m = rd | wr;
   endtask

   task automatic set_fetch(input logic [31:0] a);
      i_req  = 1'b1;
      i_addr = a;
      i_pend = 1'b1;
   endtask

   task automatic do_reset(input string tag);
      resetn   = 1'b0;
      i_req    = 1'b0;
      i_pend   = 1'b0;
      set_data(1'b0, 1'b0, '0, '0);
      step();
      step();
      check_reset(tag, 1'b0);
      resetn = 1'b1;
      model_reset();
      step();
   endtask

   // One arbitration round from IDLE: predict the winner, follow it to its done
   // pulse, then drop (or renew, when keep is set) the winner's request.
   task automatic run_round(input int lat, input bit to, input bit keep);
      bit          wd;
      bit          ewe;
      bit          st;
      logic [31:0] ea;
      logic [31:0] erd;
      int          n;
      int          elat;
      wd   = d_pend_m && (!i_pend || !last_data);
      last_data = wd;
      ea   = wd ? d_addr : i_addr;
      ewe  = wd && d_wr;
      st   = wd && d_wr;
      erd  = (to || st) ? 32'h0 : ref_read(ea);
      if (st && !to) ref_mem[ea] = d_wdata;
      if (to) err_m = 1'b1;
      if (wd) exp_d_rdata = erd;
      else    exp_i_rdata = erd;
      elat = to ? MAX_WAIT + 1 : lat + 2;
      resp_lat   = lat;
      resp_never = to;

      step();
      check_output(wd ? "grant_d_req" : "grant_i_req", 32'(mem_req), 1);
      check_output(wd ? "grant_d_we" : "grant_i_we", 32'(mem_we), 32'(ewe));
      check_output(wd ? "grant_d_addr" : "grant_i_addr", mem_addr, ea);
      if (st) check_output("grant_wdata", mem_wdata, d_wdata);
      check_output("acc_stall", 32'(stall), 1);

      n = 1;
      while (((wd ? d_done : i_done) !== 1'b1) && n < 80) begin
         step();
         n++;
         if ((wd ? d_done : i_done) !== 1'b1) begin
            check_output("acc_hold_req", 32'(mem_req), 1);
            check_output("acc_hold_addr", mem_addr, ea);
         end
      end
      check_output("done_latency", 32'(n), 32'(elat));
      check_output("other_done", 32'(wd ? i_done : d_done), 0);
      check_output("done_mem_req", 32'(mem_req), 0);
      check_output("i_rdata", i_rdata, exp_i_rdata);
      check_output("d_rdata", d_rdata, exp_d_rdata);
      check_output("err", 32'(err), 32'(err_m));
      check_output("done_stall", 32'(stall), 32'(wd ? i_pend : d_pend_m));

      if (wd) begin
         if (keep) set_data(d_rd, d_wr, rand_addr(), $urandom);
         else      set_data(1'b0, 1'b0, d_addr, d_wdata);
      end else begin
         if (keep) set_fetch(rand_addr());
         else begin
            i_req  = 1'b0;
            i_pend = 1'b0;
         end
      end
      step();
      check_output("post_i_done", 32'(i_done), 0);
      check_output("post_d_done", 32'(d_done), 0);
      check_output("post_stall", 32'(stall), 32'(i_pend | d_pend_m));
   endtask

   task automatic random_round(input bit allow_to);
      int op;
      if (!i_pend && $urandom_range(0, 1) == 1) set_fetch(rand_addr());
      if (!d_pend_m && $urandom_range(0, 1) == 1) begin
         op = int'($urandom_range(0, 2));
         set_data(op != 1, op != 0, rand_addr(), $urandom);
      end
      if (!i_pend && !d_pend_m) set_fetch(rand_addr());
      run_round(int'($urandom_range(0, 3)), allow_to && ($urandom_range(0, 9) == 0), 1'b0);
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      resetn     = 1'b0;
      i_req      = 1'b0;
      i_addr     = '0;
      i_pend     = 1'b0;
      resp_lat   = 0;
      resp_never = 1'b0;
      resp_spur  = 1'b0;
      set_data(1'b0, 1'b0, '0, '0);
      model_reset();
      env_mem[32'h40] = 32'h1234_5678;
      ref_mem[32'h40] = 32'h1234_5678;

      // Reset state
      step();
      step();
      check_reset("reset", 1'b0);
      resetn = 1'b1;
      step();
      check_output("idle_mem_req", 32'(mem_req), 0);

      // Load with two wait cycles
      set_data(1'b1, 1'b0, 32'h40, '0);
      run_round(2, 1'b0, 1'b0);
      check_output("s1_rdata", d_rdata, 32'h1234_5678);

      // Simultaneous fetch and store straight after reset
      do_reset("reset2");
      set_fetch(32'h200);
      set_data(1'b0, 1'b1, 32'h300, 32'hCAFE_F00D);
      run_round(1, 1'b0, 1'b0);
      run_round(1, 1'b0, 1'b0);

      // Zero-wait memory, contended
      set_fetch(32'h204);
      set_data(1'b1, 1'b0, 32'h300, '0);
      run_round(0, 1'b0, 1'b0);
      run_round(0, 1'b0, 1'b0);
      check_output("s6_readback", d_rdata, 32'hCAFE_F00D);

      // Continuous fetch and load requests alternate
      set_fetch(32'h400);
      set_data(1'b1, 1'b0, 32'h500, '0);
      for (int k = 0; k < 6; k++) run_round(int'($urandom_range(0, 2)), 1'b0, 1'b1);
      i_req  = 1'b0;
      i_pend = 1'b0;
      set_data(1'b0, 1'b0, '0, '0);
      step();

      // Acks while idle are ignored
      resp_spur = 1'b1;
      repeat (3) step();
      check_output("spur_mem_req", 32'(mem_req), 0);
      check_output("spur_done", 32'({i_done, d_done}), 0);
      check_output("spur_i_rdata", i_rdata, exp_i_rdata);
      check_output("spur_d_rdata", d_rdata, exp_d_rdata);
      resp_spur = 1'b0;
      repeat (2) step();

      // Timeout with no ack
      set_data(1'b1, 1'b0, 32'h600, '0);
      run_round(0, 1'b1, 1'b0);
      repeat (3) step();
      check_output("err_sticky", 32'(err), 1);

      for (int k = 0; k < 40; k++) random_round(1'b1);

      // Reset in the second ACC cycle
      set_data(1'b1, 1'b0, 32'h80, '0);
      resp_lat   = 5;
      resp_never = 1'b0;
      step();
      check_output("s5_acc1_req", 32'(mem_req), 1);
      step();
      resetn = 1'b0;
      step();
      check_reset("s5_reset", d_pend_m | i_pend);
      resetn = 1'b1;
      model_reset();
      run_round(1, 1'b0, 1'b0);

      for (int k = 0; k < 20; k++) random_round(1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
